// File: rtl/multi_width_free_list_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_width_free_list_pkg
// Description : Width helpers and modulo pointer arithmetic for the free list.
// Revision    : 1.0
// ============================================================================
package multi_width_free_list_pkg;

    localparam int c_wrap_steps = 8;

    function automatic int FreeListCountPath(input int entry_num);
        return $clog2(entry_num + 1);
    endfunction

    function automatic int FreeListIndexPath(input int entry_num);
        return $clog2(entry_num);
    endfunction

    // Depth need not be a power of two, so wrap by compare-and-correct; the
    // extra steps keep oversized (erroneous) increments inside the range.
    function automatic int WrapAdd(input int ptr, input int inc, input int entry_num);
        int sum;
        sum = ptr + inc;
        for (int i = 0; i < c_wrap_steps; i++) begin
            if (sum >= entry_num) begin
                sum = sum - entry_num;
            end else if (sum < 0) begin
                sum = sum + entry_num;
            end
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/free_list_ptr_wrap.sv
`default_nettype none
// ============================================================================
// Module      : free_list_ptr_wrap
// Description : Adds a signed increment to a pointer, wrapping mod ENTRY_NUM.
// Revision    : 1.0
// ============================================================================
module free_list_ptr_wrap #(
    parameter int ENTRY_NUM = 48,
    parameter int IDX_W     = 6,
    parameter int INC_W     = 8
) (
    input  logic [IDX_W-1:0]        i_ptr,
    input  logic signed [INC_W-1:0] i_inc,
    output logic [IDX_W-1:0]        o_ptr
);
    import multi_width_free_list_pkg::*;

    int w_sum;

    always_comb begin
        w_sum = WrapAdd(int'(i_ptr), int'(i_inc), ENTRY_NUM);
        o_ptr = IDX_W'(w_sum);
    end

endmodule
`default_nettype wire

// File: rtl/multi_width_free_list.sv
`default_nettype none
// ============================================================================
// Module      : multi_width_free_list
// Description : Circular free list of physical registers with multi-lane
//               pop/push and head rollback for mispredict recovery.
// Revision    : 1.0
// ============================================================================
module multi_width_free_list #(
    parameter int ENTRY_NUM    = 48,
    parameter int DATA_WIDTH   = 6,
    parameter int INIT_BASE    = 16,
    parameter int POP_WIDTH    = 2,
    parameter int PUSH_WIDTH   = 2,
    parameter int ROLLBACK_MAX = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [POP_WIDTH-1:0]                popReq,
    output logic                                popGrant,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]     popData,
    input  logic [PUSH_WIDTH-1:0]               pushValid,
    input  logic [PUSH_WIDTH*DATA_WIDTH-1:0]    pushData,
    input  logic                                rollbackValid,
    input  logic [$clog2(ROLLBACK_MAX+1)-1:0]   rollbackNum,
    output logic [$clog2(ENTRY_NUM+1)-1:0]      count,
    output logic                                empty,
    output logic                                error
);
    import multi_width_free_list_pkg::*;

    localparam int c_idx_w = FreeListIndexPath(ENTRY_NUM);
    localparam int c_cnt_w = FreeListCountPath(ENTRY_NUM);
    localparam int c_rb_w  = $clog2(ROLLBACK_MAX + 1);
    localparam int c_inc_w = ((c_cnt_w > c_rb_w) ? c_cnt_w : c_rb_w) + 2;

    logic [DATA_WIDTH-1:0]     r_slot [ENTRY_NUM];
    logic [c_idx_w-1:0]        r_head;
    logic [c_idx_w-1:0]        r_tail;
    logic [c_cnt_w-1:0]        r_count;
    logic                      r_error;

    logic [c_cnt_w:0]          w_pop_num;
    logic [c_cnt_w:0]          w_push_num;
    logic [c_cnt_w:0]          w_count_next;
    logic                      w_pop_contig;
    logic                      w_push_contig;
    logic                      w_err_now;
    logic signed [c_inc_w-1:0] w_pop_inc;
    logic signed [c_inc_w-1:0] w_rb_inc;
    logic signed [c_inc_w-1:0] w_push_inc;
    logic [c_idx_w-1:0]        w_head_pop;
    logic [c_idx_w-1:0]        w_head_rb;
    logic [c_idx_w-1:0]        w_tail_next;
    logic [c_idx_w-1:0]        w_rd_idx [POP_WIDTH];
    logic [c_idx_w-1:0]        w_wr_idx [PUSH_WIDTH];

    always_comb begin
        w_pop_num  = '0;
        w_push_num = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            w_pop_num = w_pop_num + (c_cnt_w+1)'(popReq[k]);
        end
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            w_push_num = w_push_num + (c_cnt_w+1)'(pushValid[k]);
        end
        // A mask is LSB-contiguous exactly when adding one clears every set bit.
        w_pop_contig  = ((popReq & (popReq + POP_WIDTH'(1))) == '0);
        w_push_contig = ((pushValid & (pushValid + PUSH_WIDTH'(1))) == '0);

        // Same-cycle pushes are deliberately not counted toward the grant.
        popGrant = (|popReq) & ~rollbackValid & ({1'b0, r_count} >= w_pop_num);

        w_count_next = {1'b0, r_count} + w_push_num
                     - (popGrant ? w_pop_num : '0)
                     + (rollbackValid ? (c_cnt_w+1)'(rollbackNum) : '0);

        w_err_now = (w_count_next > (c_cnt_w+1)'(ENTRY_NUM))
                  | ~w_pop_contig | ~w_push_contig
                  | (rollbackNum > c_rb_w'(ROLLBACK_MAX));

        w_pop_inc  = c_inc_w'(w_pop_num);
        w_push_inc = c_inc_w'(w_push_num);
        w_rb_inc   = c_inc_w'(0) - c_inc_w'(rollbackNum);
    end

    free_list_ptr_wrap #(.ENTRY_NUM(ENTRY_NUM), .IDX_W(c_idx_w), .INC_W(c_inc_w)) u_head_pop (
        .i_ptr (r_head),
        .i_inc (w_pop_inc),
        .o_ptr (w_head_pop)
    );

    free_list_ptr_wrap #(.ENTRY_NUM(ENTRY_NUM), .IDX_W(c_idx_w), .INC_W(c_inc_w)) u_head_rb (
        .i_ptr (r_head),
        .i_inc (w_rb_inc),
        .o_ptr (w_head_rb)
    );

    free_list_ptr_wrap #(.ENTRY_NUM(ENTRY_NUM), .IDX_W(c_idx_w), .INC_W(c_inc_w)) u_tail (
        .i_ptr (r_tail),
        .i_inc (w_push_inc),
        .o_ptr (w_tail_next)
    );

    generate
        for (genvar k = 0; k < POP_WIDTH; k++) begin : g_pop_lane
            assign w_rd_idx[k] = c_idx_w'(WrapAdd(int'(r_head), k, ENTRY_NUM));
            assign popData[k*DATA_WIDTH +: DATA_WIDTH] = r_slot[w_rd_idx[k]];
        end
        for (genvar k = 0; k < PUSH_WIDTH; k++) begin : g_push_lane
            assign w_wr_idx[k] = c_idx_w'(WrapAdd(int'(r_tail), k, ENTRY_NUM));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_slot[i] <= DATA_WIDTH'(INIT_BASE + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= c_cnt_w'(ENTRY_NUM);
            r_error <= 1'b0;
        end else begin
            for (int k = 0; k < PUSH_WIDTH; k++) begin
                if (pushValid[k]) begin
                    r_slot[w_wr_idx[k]] <= pushData[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (rollbackValid) begin
                r_head <= w_head_rb;
            end else if (popGrant) begin
                r_head <= w_head_pop;
            end
            r_tail  <= w_tail_next;
            r_count <= w_err_now ? c_cnt_w'(ENTRY_NUM) : c_cnt_w'(w_count_next);
            r_error <= r_error | w_err_now;
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign error = r_error;

endmodule
`default_nettype wire
